// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 byte master with multi-byte messages under one SSEL
module spi_master #(
    parameter int CLK_DIV = 2,
    parameter int SETUP   = 2,
    parameter int GAP     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  tx_data,
    input  logic        last,
    output logic        ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic [15:0] byte_cnt,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        SSEL
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_WAIT,
        S_TAIL
    } state_t;

    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_M1 = 16'(SETUP - 1);
    localparam logic [15:0] GAP_M1   = 16'(GAP - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_shift;
    logic        last_q;

    logic        accept;
    logic        phase_end;
    logic        timed;
    logic        rise_edge;
    logic        fall_edge;
    logic        byte_end;

    assign ready     = (state == S_IDLE) || (state == S_WAIT);
    assign accept    = start && ready;
    assign rise_edge = (state == S_LOW) && phase_end;
    assign fall_edge = (state == S_HIGH) && phase_end;
    assign byte_end  = fall_edge && (bit_cnt == 3'd7);

    always_comb begin
        phase_end = 1'b0;
        timed     = 1'b0;
        case (state)
            S_SETUP: begin
                timed     = 1'b1;
                phase_end = (cnt == SETUP_M1);
            end
            S_LOW, S_HIGH: begin
                timed     = 1'b1;
                phase_end = (cnt == DIV_M1);
            end
            S_TAIL: begin
                timed     = 1'b1;
                phase_end = (cnt == GAP_M1);
            end
            default: begin
                timed     = 1'b0;
                phase_end = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Zero-length SETUP or GAP collapses the phase instead of wrapping the counter.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (SETUP > 0) ? S_SETUP : S_LOW;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    if (bit_cnt != 3'd7) begin
                        state_next = S_LOW;
                    end else if (!last_q) begin
                        state_next = S_WAIT;
                    end else begin
                        state_next = (GAP > 0) ? S_TAIL : S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (accept) begin
                    state_next = S_LOW;
                end
            end
            S_TAIL: begin
                if (phase_end) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (state_next != state) begin
            cnt <= 16'd0;
        end else if (timed) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SSEL     <= 1'b1;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            byte_cnt <= 16'h0000;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            last_q   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (accept) begin
                tx_shift <= tx_data;
                last_q   <= last;
                MOSI     <= tx_data[7];
                bit_cnt  <= 3'd0;
                if (state == S_IDLE) begin
                    SSEL     <= 1'b0;
                    byte_cnt <= 16'h0000;
                end
            end

            // The slave shifts MISO after each SCK rise, so capture just before it.
            if (rise_edge) begin
                SCK      <= 1'b1;
                rx_shift <= {rx_shift[6:0], MISO};
            end

            if (fall_edge) begin
                SCK <= 1'b0;
                if (byte_end) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                    if (byte_cnt != 16'hFFFF) begin
                        byte_cnt <= byte_cnt + 16'd1;
                    end
                    if (last_q) begin
                        SSEL <= 1'b1;
                    end
                end else begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    tx_shift <= {tx_shift[6:0], 1'b0};
                    MOSI     <= tx_shift[6];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed scoreboard bench for spi_master
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, last;
    logic [7:0]  tx_data;
    logic        ready, rx_valid, sck, mosi, miso, ssel;
    logic [7:0]  rx_data;
    logic [15:0] byte_cnt;

    logic        start1, last1;
    logic [7:0]  tx_data1;
    logic        ready1, rx_valid1, sck1, mosi1, ssel1;
    logic [7:0]  rx_data1;
    logic [15:0] byte_cnt1;

    int          miso_mode;
    logic        slave_miso;

    always #5 clk = ~clk;

    assign miso = (miso_mode == 0) ? mosi : slave_miso;

    spi_master #(.CLK_DIV(2), .SETUP(2), .GAP(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .last(last),
        .ready(ready), .rx_data(rx_data), .rx_valid(rx_valid), .byte_cnt(byte_cnt),
        .SCK(sck), .MOSI(mosi), .MISO(miso), .SSEL(ssel)
    );

    spi_master #(.CLK_DIV(1), .SETUP(2), .GAP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx_data1), .last(last1),
        .ready(ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .byte_cnt(byte_cnt1),
        .SCK(sck1), .MOSI(mosi1), .MISO(1'b1), .SSEL(ssel1)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [15:0] c;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    logic [7:0] slave_q[$];

    // Mode-0 slave: first reply bit on SSEL fall, next bit after each SCK rise.
    logic [7:0] s_tx, s_rx;
    int         s_bits;
    initial begin
        slave_miso = 1'b0;
        s_tx = 8'h3C;
        s_rx = 8'h00;
        s_bits = 0;
    end
    always @(negedge ssel) begin
        s_bits = 0;
        s_tx = 8'h3C;
        slave_miso = s_tx[7];
    end
    always @(posedge sck) begin
        s_rx = {s_rx[6:0], mosi};
        if (s_bits == 7) begin
            slave_q.push_back(s_rx);
            s_bits = 0;
            s_tx = 8'h3C;
        end else begin
            s_bits++;
            s_tx = {s_tx[6:0], 1'b0};
        end
        slave_miso = s_tx[7];
    end

    int   cyc = 0;
    int   sck_rises = 0, ssel_low = 0, ssel_rises = 0, rx_cnt = 0;
    logic sck_prev = 1'b0, ssel_prev = 1'b1;
    int   sck1_rises = 0, ssel1_low = 0, rx1_cnt = 0;
    int   p1_min = 1000, p1_max = 0, last_rise1 = 0;
    logic sck1_prev = 1'b0;
    logic [7:0]  rx1_seen = 8'h00;
    logic [15:0] cnt1_seen = 16'h0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            if (sb_q.size() == 0) begin
                check("rx_unexpected", 32'(rx_valid), 0);
            end else begin
                e = sb_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.d));
                check("byte_cnt", 32'(byte_cnt), 32'(e.c));
            end
        end
        if (sck && !sck_prev) sck_rises++;
        if (!ssel) ssel_low++;
        if (ssel && !ssel_prev) ssel_rises++;
        sck_prev  = sck;
        ssel_prev = ssel;

        if (rx_valid1) begin
            rx1_cnt++;
            rx1_seen  = rx_data1;
            cnt1_seen = byte_cnt1;
        end
        if (sck1 && !sck1_prev) begin
            if (sck1_rises > 0) begin
                if (cyc - last_rise1 < p1_min) p1_min = cyc - last_rise1;
                if (cyc - last_rise1 > p1_max) p1_max = cyc - last_rise1;
            end
            last_rise1 = cyc;
            sck1_rises++;
        end
        if (!ssel1) ssel1_low++;
        sck1_prev = sck1;
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 1);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        wait_ready();
        start = 1'b1;
        tx_data = d;
        last = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(ssel && ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(ssel && ready)) check("done_timeout", 0, 1);
    endtask

    task automatic check_slave(input string tag, input logic [7:0] exp);
        if (slave_q.size() == 0) check({tag, "_missing"}, 0, 1);
        else check(tag, 32'(slave_q.pop_front()), 32'(exp));
    endtask

    int b_rise, b_low, b_rx, b_srise, n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; tx_data = 8'h00; last = 1'b0;
        start1 = 1'b0; tx_data1 = 8'h00; last1 = 1'b0;
        miso_mode = 0;
        repeat (3) @(negedge clk);
        check("rst_ssel", 32'(ssel), 1);
        check("rst_sck", 32'(sck), 0);
        check("rst_ready", 32'(ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ssel", 32'(ssel), 1);
        check("idle_sck", 32'(sck), 0);
        check("idle_mosi", 32'(mosi), 0);
        check("idle_ready", 32'(ready), 1);
        check("idle_rx_valid", 32'(rx_valid), 0);
        check("idle_byte_cnt", 32'(byte_cnt), 0);
        check("idle_rx_data", 32'(rx_data), 0);

        // Single byte, loopback
        b_rise = sck_rises; b_low = ssel_low; b_rx = rx_cnt;
        sb_q.push_back('{8'hA5, 16'd1});
        send(8'hA5, 1'b1);
        wait_done();
        check("a5_sck_rises", 32'(sck_rises - b_rise), 8);
        check("a5_ssel_low", 32'(ssel_low - b_low), 34);
        check("a5_rx_count", 32'(rx_cnt - b_rx), 1);
        check_slave("a5_mosi", 8'hA5);

        // Three-byte message against the slave model
        miso_mode = 1;
        b_rx = rx_cnt; b_srise = ssel_rises;
        sb_q.push_back('{8'h3C, 16'd1});
        sb_q.push_back('{8'h3C, 16'd2});
        sb_q.push_back('{8'h3C, 16'd3});
        send(8'h81, 1'b0);
        @(negedge clk);
        wait_ready();
        check("wait1_ssel", 32'(ssel), 0);
        send(8'h00, 1'b0);
        @(negedge clk);
        wait_ready();
        check("wait2_ssel", 32'(ssel), 0);
        check("wait2_byte_cnt", 32'(byte_cnt), 2);
        send(8'hFF, 1'b1);
        wait_done();
        check("msg3_ssel_rises", 32'(ssel_rises - b_srise), 1);
        check("msg3_rx_count", 32'(rx_cnt - b_rx), 3);
        check_slave("msg3_cmd", 8'h81);
        check_slave("msg3_p0", 8'h00);
        check_slave("msg3_p1", 8'hFF);

        // Starts during HIGH and TAIL are ignored
        miso_mode = 0;
        b_rise = sck_rises; b_low = ssel_low; b_rx = rx_cnt;
        sb_q.push_back('{8'h5A, 16'd1});
        send(8'h5A, 1'b1);
        n = 0;
        while (!sck && n < 200) begin @(negedge clk); n++; end
        check("high_ready", 32'(ready), 0);
        start = 1'b1; tx_data = 8'hFF; last = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!ssel && n < 200) begin @(negedge clk); n++; end
        check("tail_ready", 32'(ready), 0);
        start = 1'b1; tx_data = 8'hFF; last = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        check("ign_sck_rises", 32'(sck_rises - b_rise), 8);
        check("ign_ssel_low", 32'(ssel_low - b_low), 34);
        check("ign_rx_count", 32'(rx_cnt - b_rx), 1);
        check_slave("ign_mosi", 8'h5A);

        // Reset mid-byte aborts, then a fresh byte completes
        b_rise = sck_rises; b_rx = rx_cnt;
        send(8'hF0, 1'b1);
        n = 0;
        while (sck_rises - b_rise < 4 && n < 200) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        check("abort_ssel", 32'(ssel), 1);
        check("abort_sck", 32'(sck), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("abort_rx_count", 32'(rx_cnt - b_rx), 0);
        b_rise = sck_rises; b_low = ssel_low; b_rx = rx_cnt;
        sb_q.push_back('{8'h0F, 16'd1});
        send(8'h0F, 1'b1);
        check("post_rst_accept", 32'(ssel), 0);
        wait_done();
        check("post_rst_sck_rises", 32'(sck_rises - b_rise), 8);
        check("post_rst_ssel_low", 32'(ssel_low - b_low), 34);
        check("post_rst_rx_count", 32'(rx_cnt - b_rx), 1);
        check_slave("post_rst_mosi", 8'h0F);

        // CLK_DIV=1 instance with MISO held high
        n = 0;
        while (!ready1 && n < 200) begin @(negedge clk); n++; end
        b_low = ssel1_low;
        start1 = 1'b1; tx_data1 = 8'h00; last1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!(ssel1 && ready1) && n < 200) begin @(negedge clk); n++; end
        check("div1_sck_rises", 32'(sck1_rises), 8);
        check("div1_period_min", 32'(p1_min), 2);
        check("div1_period_max", 32'(p1_max), 2);
        check("div1_ssel_low", 32'(ssel1_low - b_low), 18);
        check("div1_rx_count", 32'(rx1_cnt), 1);
        check("div1_rx_data", 32'(rx1_seen), 32'h0000_00FF);
        check("div1_byte_cnt", 32'(cnt1_seen), 1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per SCK half-period, legal values >=1.
REQ-002 SHALL have parameter SETUP, default 2: clk cycles from the SSEL falling edge to the first SCK phase.
REQ-003 SHALL have parameter GAP, default 2: minimum clk cycles SSEL stays high after a message.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to send tx_data.
REQ-008 tx_data  in  8  byte to transmit, MSB first.
REQ-009 last  in  1  qualifies start; 1 = end the message after this byte.
REQ-010 ready  out  1  high when start is accepted.
REQ-011 rx_data  out  8  byte shifted in from MISO.
REQ-012 rx_valid  out  1  one-cycle pulse, rx_data is valid.
REQ-013 byte_cnt  out  16  bytes completed in the current message.
REQ-014 SCK  out  1  SPI clock, mode 0 (idle low).
REQ-015 MOSI  out  1  serial data to the slave.
REQ-016 MISO  in  1  serial data from the slave.
REQ-017 SSEL  out  1  slave select, active low.

Function
REQ-018 SHALL implement the states IDLE, SETUP, LOW, HIGH, WAIT and TAIL.
REQ-019 SHALL drive ready=1 only in IDLE or WAIT; start with ready=0 is ignored, with no state change.
REQ-020 On accepted start, SHALL latch tx_data and last in the same cycle.
REQ-021 Start in IDLE SHALL: drive SSEL=0 the next cycle; clear byte_cnt to 0; drive MOSI=tx_data[7]; enter SETUP.
REQ-022 SETUP SHALL last SETUP cycles with SCK=0, then enter LOW.
REQ-023 LOW SHALL last CLK_DIV cycles with SCK=0, then enter HIGH.
REQ-024 HIGH SHALL last CLK_DIV cycles with SCK=1, then SCK returns to 0.
REQ-025 SHALL sample MISO into the receive shift register on the clk edge that drives SCK high, because the slave updates MISO after each SCK rise.
REQ-026 MOSI SHALL change only on the clk edge that drives SCK low, advancing to the next lower bit, so it is stable for the whole SCK-high phase.
REQ-027 After the 8th HIGH phase, on the clk edge driving SCK low, SHALL:
- load rx_data;
- pulse rx_valid for exactly 1 cycle;
- increment byte_cnt, saturating at 16'hFFFF.
REQ-028 After the 8th HIGH phase, if the latched last=0, SHALL enter WAIT with SSEL=0, SCK=0 and MOSI holding its value.
REQ-029 After the 8th HIGH phase, if the latched last=1, SHALL enter TAIL, driving SSEL=1 on that same edge.
REQ-030 Start in WAIT SHALL enter LOW directly (no SETUP) with MOSI=tx_data[7].
REQ-031 WAIT has no timeout; SSEL stays low indefinitely.
REQ-032 TAIL SHALL last GAP cycles, then enter IDLE; start during TAIL is ignored (ready=0).
REQ-033 Each byte SHALL take 16*CLK_DIV clk cycles from entering LOW to the edge driving SCK low after bit 8.
REQ-034 For a single-byte message, SSEL SHALL be low for exactly SETUP+16*CLK_DIV cycles.
REQ-035 SHALL produce exactly 8 SCK rising edges per byte, with no SCK glitches or partial pulses.
REQ-036 SCK, SSEL and MOSI SHALL be driven directly from flip-flops.

Reset
REQ-037 While rst_n=0, SHALL set, asynchronously: state=IDLE, SSEL=1, SCK=0, MOSI=0, ready=1, rx_valid=0, rx_data=8'h00, byte_cnt=16'h0000.
REQ-038 Reset asserted mid-byte SHALL abort the transfer immediately: no rx_valid, no partial SCK pulse after the reset edge.
REQ-039 After rst_n deasserts, start SHALL be accepted on the first clk edge.

Verification
REQ-040 Reset, then observe before any start -> SSEL=1, SCK=0, MOSI=0, ready=1, rx_valid=0, byte_cnt=0.
REQ-041 CLK_DIV=2, SETUP=2; start with tx_data=8'hA5, last=1; MISO looped to MOSI -> 8 SCK pulses, SSEL low for 34 cycles, one rx_valid with rx_data=8'hA5, byte_cnt=1.
REQ-042 Three-byte message 8'h81, 8'h00, 8'hFF (last only on the third), driven by an instance of the team's SPI slave receiver replying 8'h3C -> SSEL stays low throughout; slave reports cmd 8'h81 then params 8'h00, 8'hFF; three rx_valid pulses each with rx_data=8'h3C; byte_cnt steps 1, 2, 3.
REQ-043 start pulsed during HIGH and during TAIL -> ignored; MOSI/SCK sequence unchanged; total rx_valid count unchanged.
REQ-044 rst_n pulled low after 4 SCK rises of byte 8'hF0 -> SSEL=1 and SCK=0 before the next clk edge; no rx_valid; a new start with 8'h0F then completes normally.
REQ-045 CLK_DIV=1, MISO held 1, start with 8'h00, last=1 -> SCK period 2 clk cycles; rx_data=8'hFF; SSEL low for SETUP+16 cycles.
